// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with row synchronizer, press/release
// debounce and decode into the digital_lock command interface.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_in,
  output logic       key_press,
  output logic       enter,
  output logic       clear,
  output logic       change_pwd_mode,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, PRESS_DB, EMIT, REL_DB} state_e;
  typedef enum logic [2:0] {K_DIGIT, K_ENTER, K_CLEAR, K_MODE, K_NONE} kind_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, rs_q;
  logic [3:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_code_q, row_code_d;
  logic [3:0]       key_in_q, key_in_d;
  logic             key_press_q, key_press_d;
  logic             enter_q, enter_d;
  logic             clear_q, clear_d;
  logic             mode_q, mode_d;
  logic             key_held_q, key_held_d;

  logic [1:0]       row_idx, col_idx;
  kind_e            kind;
  logic [3:0]       digit;
  logic [3:0]       col_next;

  assign col_out         = col_q;
  assign key_in          = key_in_q;
  assign key_press       = key_press_q;
  assign enter           = enter_q;
  assign clear           = clear_q;
  assign change_pwd_mode = mode_q;
  assign key_held        = key_held_q;

  assign col_next = {col_q[2:0], col_q[3]};

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= row_in;
      rs_q    <= sync1_q;
    end
  end

  // Decode latched row code and frozen column into a key; lowest row wins.
  always_comb begin
    row_idx = 2'd3;
    if (!row_code_q[0])      row_idx = 2'd0;
    else if (!row_code_q[1]) row_idx = 2'd1;
    else if (!row_code_q[2]) row_idx = 2'd2;
    col_idx = 2'd3;
    if (!col_q[0])      col_idx = 2'd0;
    else if (!col_q[1]) col_idx = 2'd1;
    else if (!col_q[2]) col_idx = 2'd2;
    kind  = K_NONE;
    digit = 4'd0;
    case ({row_idx, col_idx})
      4'h0: begin kind = K_DIGIT; digit = 4'd1; end
      4'h1: begin kind = K_DIGIT; digit = 4'd2; end
      4'h2: begin kind = K_DIGIT; digit = 4'd3; end
      4'h3: kind = K_MODE;
      4'h4: begin kind = K_DIGIT; digit = 4'd4; end
      4'h5: begin kind = K_DIGIT; digit = 4'd5; end
      4'h6: begin kind = K_DIGIT; digit = 4'd6; end
      4'h8: begin kind = K_DIGIT; digit = 4'd7; end
      4'h9: begin kind = K_DIGIT; digit = 4'd8; end
      4'hA: begin kind = K_DIGIT; digit = 4'd9; end
      4'hC: kind = K_CLEAR;
      4'hD: begin kind = K_DIGIT; digit = 4'd0; end
      4'hE: kind = K_ENTER;
      default: kind = K_NONE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_q       <= 4'b1110;
      div_q       <= '0;
      cnt_q       <= '0;
      row_code_q  <= 4'hF;
      key_in_q    <= 4'd0;
      key_press_q <= 1'b0;
      enter_q     <= 1'b0;
      clear_q     <= 1'b0;
      mode_q      <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      row_code_q  <= row_code_d;
      key_in_q    <= key_in_d;
      key_press_q <= key_press_d;
      enter_q     <= enter_d;
      clear_q     <= clear_d;
      mode_q      <= mode_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state and output logic; pulses are raised on the edge entering EMIT.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    row_code_d  = row_code_q;
    key_in_d    = key_in_q;
    key_held_d  = key_held_q;
    key_press_d = 1'b0;
    enter_d     = 1'b0;
    clear_d     = 1'b0;
    mode_d      = 1'b0;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs_q == 4'hF) begin
            col_d = col_next;
          end else begin
            row_code_d = rs_q;
            cnt_d      = '0;
            state_d    = PRESS_DB;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PRESS_DB: begin
        if (rs_q != row_code_q) begin
          cnt_d   = '0;
          div_d   = '0;
          state_d = SCAN;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_LAST) begin
            state_d    = EMIT;
            key_held_d = 1'b1;
            case (kind)
              K_DIGIT: begin key_press_d = 1'b1; key_in_d = digit; end
              K_ENTER: enter_d = 1'b1;
              K_CLEAR: clear_d = 1'b1;
              K_MODE:  mode_d  = 1'b1;
              default: ;
            endcase
          end
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = REL_DB;
      end
      REL_DB: begin
        if (rs_q != 4'hF) begin
          cnt_d = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_LAST) begin
            cnt_d      = '0;
            div_d      = '0;
            col_d      = col_next;
            key_held_d = 1'b0;
            state_d    = SCAN;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

endmodule
